sub_bytes_seq: RTL and testbench
================================

# sub_bytes_seq

Iterative AES SubBytes stage directly upstream of the ShiftRows stage. It accepts a 128-bit state over a valid/ready handshake and substitutes SBOX_PER_CYCLE bytes per clock through a shared bank of S-boxes, trading latency for area. It presents the fully substituted state on a valid/ready output that feeds ShiftRows' `IN`. The inverse S-box, used for decryption, is a compile-time option.

## Interface
- `BLOCK_LENGTH`, 128: state width; only 128 is supported.
- `SBOX_PER_CYCLE`, 4: S-boxes instantiated; legal values 1, 2, 4, 8, 16. N_CYC = 16/SBOX_PER_CYCLE.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: synchronous reset, active-high.
- `IN_VALID` input 1: `IN` holds a state to be processed.
- `IN_READY` output 1: block can accept a state this cycle.
- `IN` input 128: input state; byte 0 = `IN[127:120]`, byte 15 = `IN[7:0]`.
- `INV` input 1: sampled with `IN`; 1 selects inverse S-box (see Configuration).
- `OUT_VALID` output 1: `OUT` holds a completed state.
- `OUT_READY` input 1: consumer accepts `OUT` this cycle.
- `OUT` output 128: substituted state, same byte order as `IN`.

## Operation
- State register `st[127:0]`, group counter `cnt` of width clog2(N_CYC) (minimum 1 bit), mode flag `inv_q`, and FSM with states IDLE, RUN, DONE.
- IDLE: `IN_READY`=1. On `IN_VALID`, at the next edge: `st`<=`IN`, `inv_q`<=`INV`, `cnt`<=0, go to RUN.
- RUN: at each edge, bytes cnt*SBOX_PER_CYCLE through cnt*SBOX_PER_CYCLE+SBOX_PER_CYCLE-1 of `st` are replaced by S(byte), or S⁻¹(byte) if `inv_q`; `cnt` increments. At the edge where `cnt`=N_CYC-1, `cnt` wraps to 0 and the FSM goes to DONE. Input is ignored in RUN: `IN_READY`=0.
- DONE: `OUT_VALID`=1 and `OUT`=`st`, both held stable until `OUT_READY`=1.
  - `OUT_READY`=1 with no new input: go to IDLE.
  - `IN_READY` = `OUT_READY` in DONE. If `OUT_READY` and `IN_VALID` are both 1, the output is consumed and the new state is loaded at the same edge, going directly to RUN. This allows back-to-back operation with no IDLE bubble.
- `OUT` always drives `st`. Its contents are meaningful only while `OUT_VALID`=1.
- S-box is the combinational FIPS-197 table lookup. There are no data-dependent stalls.

## Timing
- Reset values: `IN_READY`=0 during the reset cycle, then 1 (IDLE); `OUT_VALID`=0; `OUT`=0; `cnt`=0; `inv_q`=0.
- Latency: `OUT_VALID` rises N_CYC clocks after the accept edge. With the default of 4, accept at edge E0 gives `OUT_VALID` high after E4.
- Throughput: one state per N_CYC+1 clocks with continuous ready and valid. Example: SBOX_PER_CYCLE=16 gives one state every 2 clocks.
- `IN_READY` and `OUT_VALID` are registered-state decodes. `IN_READY` depends combinationally on `OUT_READY` in DONE only.
- `OUT_VALID` never drops without `OUT_READY`. `OUT` never changes while `OUT_VALID`=1 and `OUT_READY`=0.
- `RST` asserted in any state, including mid-RUN: the next edge returns to IDLE with reset values, and the in-flight state is discarded.
- `IN_VALID` while `IN_READY`=0: ignored; no capture.

## Configuration
- `SUB_BYTES_INV_SBOX_EN` defined: the inverse S-box table is compiled in, and `inv_q`=1 selects S⁻¹ per byte.
- Not defined: there is no inverse table. `INV` is ignored and `inv_q` is held at 0, so only the forward S-box is used. The port list is unchanged.

## Test plan
- Reset, then idle: `RST`=1 for 2 cycles → `OUT_VALID`=0, `OUT`=0; `IN_READY`=1 the cycle after `RST` falls.
- FIPS-197 App. B: `IN`=193de3bea0f4e22b9ac68d2ae9f84808, `INV`=0, `OUT_READY`=1 → `OUT`=d42711aee0bf98f1b8b45de51e415230, with `OUT_VALID` high exactly N_CYC clocks after accept. Repeat for SBOX_PER_CYCLE = 1, 4, 16 (latency 16, 4, 1).
- Backpressure: all-zero input, `OUT_READY`=0 for 10 cycles → `OUT`=6363…63 (16 bytes) held stable, `IN_READY`=0. Raise `OUT_READY` together with `IN_VALID` carrying 53 repeated → same-edge handoff; next result is ED repeated.
- Inverse (macro defined): `IN`=d42711aee0bf98f1b8b45de51e415230, `INV`=1 → `OUT`=193de3bea0f4e22b9ac68d2ae9f84808. Without the macro, the same stimulus → forward S-box result.
- Reset mid-RUN: assert `RST` two cycles after accept → IDLE next edge, `OUT_VALID` stays 0. A new input afterwards completes with correct data.
- Ignored input: toggle `IN_VALID` with a different `IN` during RUN → the result matches only the originally accepted state.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: iterative AES SubBytes feeding ShiftRows.
// A 128-bit state is accepted over valid/ready. SBOX_PER_CYCLE bytes are
// substituted per clock through a shared S-box bank, so a state takes
// N_CYC = 16/SBOX_PER_CYCLE clocks. The result is then held on OUT until
// the consumer takes it.
// Optional feature macro: SUB_BYTES_INV_SBOX_EN compiles in the inverse
// S-box, and INV (captured with IN) then selects it. Without the macro only
// the forward table exists, and INV is ignored.
//
// state | meaning
// IDLE  | empty, IN_READY=1, waiting for IN_VALID
// RUN   | substituting one byte group per clock, input ignored
// DONE  | OUT_VALID=1, result held until OUT_READY; may reload same edge
module sub_bytes_seq #(
  parameter int BLOCK_LENGTH   = 128,
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic                    INV,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [BLOCK_LENGTH-1:0] OUT
);

  localparam int N_CYC = 16 / SBOX_PER_CYCLE;
  localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);

  // Entry b of each table sits at bits [8*(255-b) +: 8], so row 0 is in the MSBs.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTES_INV_SBOX_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[8*(255 - int'(b)) +: 8];
  endfunction
`endif

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[8*(255 - int'(b)) +: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [BLOCK_LENGTH-1:0] st;
  logic [BLOCK_LENGTH-1:0] st_sub;
  logic [CNT_W-1:0]        cnt;
  logic                    inv_q;
  logic                    load;
  int                      pos;

`ifndef SUB_BYTES_INV_SBOX_EN
  logic unused_inv;
  assign unused_inv = INV ^ inv_q;
`endif

  // IN_READY is forced low while RST is held so nothing looks accepted mid-reset.
  assign IN_READY  = !RST && ((state == IDLE) || ((state == DONE) && OUT_READY));
  assign OUT_VALID = (state == DONE);
  assign OUT       = st;
  assign load      = IN_VALID && IN_READY;

  // Substitute the byte group selected by cnt; all other bytes pass through.
  always_comb begin
    st_sub = st;
    pos    = 0;
    for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
      pos = BLOCK_LENGTH - 1 - 8 * (int'(cnt) * SBOX_PER_CYCLE + k);
`ifdef SUB_BYTES_INV_SBOX_EN
      st_sub[pos -: 8] = inv_q ? sbox_inv(st[pos -: 8]) : sbox_fwd(st[pos -: 8]);
`else
      st_sub[pos -: 8] = sbox_fwd(st[pos -: 8]);
`endif
    end
  end

  // Control FSM, state register, group counter and mode flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      st    <= '0;
      cnt   <= '0;
      inv_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            st    <= IN;
`ifdef SUB_BYTES_INV_SBOX_EN
            inv_q <= INV;
`else
            inv_q <= 1'b0;
`endif
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          st <= st_sub;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (OUT_READY) begin
            if (load) begin
              st    <= IN;
`ifdef SUB_BYTES_INV_SBOX_EN
              inv_q <= INV;
`else
              inv_q <= 1'b0;
`endif
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq at the default SBOX_PER_CYCLE of 4.
// Accepted inputs push their hand-computed result into a queue. A monitor
// pops that queue on every output handshake, and it also checks the
// latency, the hold-under-backpressure behaviour and the handoff.
module tb_sub_bytes_seq;

  localparam int SPC   = 4;
  localparam int N_CYC = 16 / SPC;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;

  typedef struct {
    logic [127:0] data;
    int           acc_cyc;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] drv_exp;
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] APPB_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZERO_OUT  = {16{8'h63}};
  localparam logic [127:0] B53_IN    = {16{8'h53}};
  localparam logic [127:0] B53_OUT   = {16{8'hed}};
  localparam logic [127:0] SEQ_IN    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SEQ_OUT   = 128'h638293c31bfc33f5c4eeacea4bc12816;
`ifdef SUB_BYTES_INV_SBOX_EN
  localparam logic [127:0] INV_OUT   = APPB_IN;
`else
  localparam logic [127:0] INV_OUT   = 128'h48cc82e4e10846a16c8d4cd972830004;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_seq #(.BLOCK_LENGTH(128), .SBOX_PER_CYCLE(SPC)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN        (din),
    .INV       (inv),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT       (dout)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, expv);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: sample between edges, match outputs against the queue.
  logic         vld_prev   = 1'b0;
  logic         stall_prev = 1'b0;
  logic [127:0] out_prev   = '0;

  always @(negedge clk) begin
    if (rst) begin
      vld_prev   <= 1'b0;
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk_b("hold_valid", out_valid, 1'b1);
        chk("hold_data", dout, out_prev);
      end
      if (out_valid && !out_ready)
        chk_b("stall_in_ready", in_ready, 1'b0);
      if (out_valid && !vld_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", dout);
        end else begin
          chk_int("latency", cyc, sb_q[0].acc_cyc + N_CYC);
        end
      end
      if (out_valid && out_ready && sb_q.size() != 0) begin
        chk("data", dout, sb_q[0].data);
        void'(sb_q.pop_front());
      end
      if (in_valid && in_ready)
        sb_q.push_back('{drv_exp, cyc + 1});
      vld_prev   <= out_valid;
      stall_prev <= out_valid && !out_ready;
      out_prev   <= dout;
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [127:0] d, input logic iv, input logic [127:0] e);
    bit ok = 1'b0;
    din      = d;
    inv      = iv;
    drv_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    inv       = 1'b0;
    drv_exp   = '0;

    // Reset held for two cycles.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", dout, '0);
    chk_b("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_b("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // FIPS-197 Appendix B round-1 SubBytes.
    send(APPB_IN, 1'b0, APPB_OUT);
    wait_drain();

    // Backpressure with all-zero input, then same-edge handoff.
    out_ready = 1'b0;
    send('0, 1'b0, ZERO_OUT);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(B53_IN, 1'b0, B53_OUT);
    wait_drain();

    // INV request: inverse result with the table, forward result without it.
    send(APPB_OUT, 1'b1, INV_OUT);
    wait_drain();

    // A different input offered during RUN must not be captured.
    send(SEQ_IN, 1'b0, SEQ_OUT);
    din      = '1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = '0;
    wait_drain();

    // Reset two cycles after accept discards the in-flight state.
    send(APPB_IN, 1'b0, APPB_OUT);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_b("midrun_rst_no_valid", out_valid, 1'b0);
    end
    chk_b("midrun_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send('0, 1'b0, ZERO_OUT);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
